multicycle_controller: RTL and testbench

//  Main control FSM plus ALU decoder for the multicycle RV32I core (lw, sw, R-type, I-type ALU, beq, jal).

---
 rtl/multicycle_controller_pkg.sv | 65 ++++++
 rtl/multicycle_controller_if.sv | 33 +++
 rtl/multicycle_controller_alu_decoder.sv | 31 +++
 rtl/multicycle_controller.sv | 136 +++++++++++++
 tb/tb_multicycle_controller.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/multicycle_controller_pkg.sv
// rtl/multicycle_controller_pkg.sv - opcodes, state encoding and datapath select encodings for the multicycle RV32I controller
package multicycle_controller_pkg;

  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_JAL      = 4'd9,
    S_BEQ      = 4'd10,
    S_TRAP     = 4'd11
  } state_e;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluop_e;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  // Extender format follows the opcode alone, independent of FSM state.
  function automatic logic [1:0] imm_src_of(input logic [6:0] op);
    case (op)
      OP_SW:   return IMM_S;
      OP_BEQ:  return IMM_B;
      OP_JAL:  return IMM_J;
      default: return IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// rtl/multicycle_controller_if.sv - instruction fields, status flags and datapath controls between controller and datapath
interface multicycle_controller_if;

  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
  logic       mem_ready;
  logic [1:0] immsrc;
  logic [1:0] alusrca;
  logic [1:0] alusrcb;
  logic [1:0] resultsrc;
  logic [2:0] alucontrol;
  logic       adrsrc;
  logic       irwrite;
  logic       pcwrite;
  logic       regwrite;
  logic       memwrite;
  logic       illegal;

  modport master (
    input  op, funct3, funct7b5, zero, mem_ready,
    output immsrc, alusrca, alusrcb, resultsrc, alucontrol,
           adrsrc, irwrite, pcwrite, regwrite, memwrite, illegal
  );

  modport slave (
    output op, funct3, funct7b5, zero, mem_ready,
    input  immsrc, alusrca, alusrcb, resultsrc, alucontrol,
           adrsrc, irwrite, pcwrite, regwrite, memwrite, illegal
  );

endinterface

// File: rtl/multicycle_controller_alu_decoder.sv
// rtl/multicycle_controller_alu_decoder.sv - maps aluop and funct fields to the ALU operation code
module alu_decoder
  import multicycle_controller_pkg::*;
(
  input  aluop_e     aluop,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       op5,
  output logic [2:0] alucontrol
);

  always_comb begin
    alucontrol = ALU_ADD;
    case (aluop)
      ALUOP_ADD: alucontrol = ALU_ADD;
      ALUOP_SUB: alucontrol = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          // Only R-type may subtract; addi with imm[10]=1 must stay an add.
          3'b000:  alucontrol = (op5 & funct7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  alucontrol = ALU_SLT;
          3'b110:  alucontrol = ALU_OR;
          3'b111:  alucontrol = ALU_AND;
          default: alucontrol = ALU_ADD;
        endcase
      end
      default: alucontrol = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - main control FSM sequencing the shared ALU, memory port and extender
module multicycle_controller
  import multicycle_controller_pkg::*;
#(
  parameter bit ILLEGAL_TRAP = 1'b1
) (
  input logic                     clk,
  input logic                     reset_n,
  multicycle_controller_if.master ctl
);

  state_e     state_q, state_d;
  aluop_e     aluop;
  logic [1:0] alusrca, alusrcb, resultsrc;
  logic       adrsrc, irwrite, pcwrite, regwrite, memwrite, illegal;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_FETCH;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:    if (ctl.mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (ctl.op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXECR;
          OP_ITYPE:     state_d = S_EXECI;
          OP_JAL:       state_d = S_JAL;
          OP_BEQ:       state_d = S_BEQ;
          default:      state_d = ILLEGAL_TRAP ? S_TRAP : S_FETCH;
        endcase
      end
      S_MEMADR:   state_d = (ctl.op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  if (ctl.mem_ready) state_d = S_MEMWB;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: if (ctl.mem_ready) state_d = S_FETCH;
      S_EXECR:    state_d = S_ALUWB;
      S_EXECI:    state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_JAL:      state_d = S_ALUWB;
      S_BEQ:      state_d = S_FETCH;
      S_TRAP:     state_d = S_TRAP;
      default:    state_d = S_FETCH;
    endcase
  end

  always_comb begin
    aluop     = ALUOP_ADD;
    alusrca   = SRCA_PC;
    alusrcb   = SRCB_RS2;
    resultsrc = RES_ALUOUT;
    adrsrc    = 1'b0;
    irwrite   = 1'b0;
    pcwrite   = 1'b0;
    regwrite  = 1'b0;
    memwrite  = 1'b0;
    illegal   = 1'b0;
    case (state_q)
      S_FETCH: begin
        alusrcb   = SRCB_FOUR;
        resultsrc = RES_ALURESULT;
        irwrite   = ctl.mem_ready;
        pcwrite   = ctl.mem_ready;
      end
      S_DECODE: begin
        alusrca = SRCA_OLDPC;
        alusrcb = SRCB_IMM;
      end
      S_MEMADR: begin
        alusrca = SRCA_RS1;
        alusrcb = SRCB_IMM;
      end
      S_MEMREAD:  adrsrc = 1'b1;
      S_MEMWB: begin
        resultsrc = RES_DATA;
        regwrite  = 1'b1;
      end
      S_MEMWRITE: begin
        adrsrc   = 1'b1;
        memwrite = 1'b1;
      end
      S_EXECR: begin
        alusrca = SRCA_RS1;
        aluop   = ALUOP_FUNCT;
      end
      S_EXECI: begin
        alusrca = SRCA_RS1;
        alusrcb = SRCB_IMM;
        aluop   = ALUOP_FUNCT;
      end
      S_ALUWB:    regwrite = 1'b1;
      S_JAL: begin
        alusrca = SRCA_OLDPC;
        alusrcb = SRCB_FOUR;
        pcwrite = 1'b1;
      end
      S_BEQ: begin
        alusrca = SRCA_RS1;
        aluop   = ALUOP_SUB;
        pcwrite = ctl.zero;
      end
      S_TRAP:     illegal = 1'b1;
      default:    ;
    endcase
    // FETCH is entered asynchronously, so its mem_ready-driven enables must be masked during reset.
    if (!reset_n) begin
      irwrite  = 1'b0;
      pcwrite  = 1'b0;
      regwrite = 1'b0;
      memwrite = 1'b0;
    end
  end

  alu_decoder u_alu_decoder (
    .aluop      (aluop),
    .funct3     (ctl.funct3),
    .funct7b5   (ctl.funct7b5),
    .op5        (ctl.op[5]),
    .alucontrol (ctl.alucontrol)
  );

  assign ctl.immsrc    = imm_src_of(ctl.op);
  assign ctl.alusrca   = alusrca;
  assign ctl.alusrcb   = alusrcb;
  assign ctl.resultsrc = resultsrc;
  assign ctl.adrsrc    = adrsrc;
  assign ctl.irwrite   = irwrite;
  assign ctl.pcwrite   = pcwrite;
  assign ctl.regwrite  = regwrite;
  assign ctl.memwrite  = memwrite;
  assign ctl.illegal   = illegal;

endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - self-checking bench: per-instruction cycle traces built from the control table
module tb_multicycle_controller;

  typedef struct packed {
    logic [1:0] immsrc;
    logic [1:0] alusrca;
    logic [1:0] alusrcb;
    logic [1:0] resultsrc;
    logic [2:0] aluc;
    logic       adrsrc;
    logic       irwrite;
    logic       pcwrite;
    logic       regwrite;
    logic       memwrite;
    logic       illegal;
  } outv_t;

  typedef struct packed {
    outv_t e;
    logic  mr;
    logic  z;
  } step_t;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
  logic       mem_ready;
  int         checks = 0;
  int         errors = 0;
  step_t      plan[$];

  always #5 clk = ~clk;

  multicycle_controller_if if_t ();
  multicycle_controller_if if_n ();

  assign if_t.op = op;  assign if_t.funct3 = funct3;  assign if_t.funct7b5 = funct7b5;
  assign if_t.zero = zero;  assign if_t.mem_ready = mem_ready;
  assign if_n.op = op;  assign if_n.funct3 = funct3;  assign if_n.funct7b5 = funct7b5;
  assign if_n.zero = zero;  assign if_n.mem_ready = mem_ready;

  multicycle_controller #(.ILLEGAL_TRAP(1'b1)) dut_t (.clk(clk), .reset_n(reset_n), .ctl(if_t));
  multicycle_controller #(.ILLEGAL_TRAP(1'b0)) dut_n (.clk(clk), .reset_n(reset_n), .ctl(if_n));

  logic [16:0] obs_t, obs_n;
  assign obs_t = {if_t.immsrc, if_t.alusrca, if_t.alusrcb, if_t.resultsrc, if_t.alucontrol,
                  if_t.adrsrc, if_t.irwrite, if_t.pcwrite, if_t.regwrite, if_t.memwrite, if_t.illegal};
  assign obs_n = {if_n.immsrc, if_n.alusrca, if_n.alusrcb, if_n.resultsrc, if_n.alucontrol,
                  if_n.adrsrc, if_n.irwrite, if_n.pcwrite, if_n.regwrite, if_n.memwrite, if_n.illegal};

  function automatic outv_t mk(input logic [1:0] imm, a, b, r, input logic [2:0] alu,
                               input logic adr, irw, pcw, rw, mw, ill);
    return '{imm, a, b, r, alu, adr, irw, pcw, rw, mw, ill};
  endfunction

  function automatic logic [1:0] exp_imm(input logic [6:0] o);
    case (o)
      7'h23:   return 2'b01;
      7'h63:   return 2'b10;
      7'h6F:   return 2'b11;
      default: return 2'b00;
    endcase
  endfunction

  // ALU operation the instruction semantically asks for.
  function automatic logic [2:0] exp_alu(input logic [6:0] o, input logic [2:0] f3, input logic f7);
    case (f3)
      3'd0:    return (o == 7'h33 && f7) ? 3'b001 : 3'b000;
      3'd2:    return 3'b101;
      3'd6:    return 3'b011;
      3'd7:    return 3'b010;
      default: return 3'b000;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [16:0] obs, input logic [16:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input outv_t e, input logic mr);
    plan.push_back('{e, mr, 1'($urandom_range(0, 1))});
  endtask

  // Expected per-cycle outputs for one instruction, including memory wait cycles.
  task automatic plan_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                            input logic z, input int fw, input int mwait);
    logic [1:0] im;
    step_t s;
    im = exp_imm(o);
    for (int i = 0; i < fw; i++) push(mk(im, 0, 2, 2, 0, 0, 0, 0, 0, 0, 0), 1'b0);
    push(mk(im, 0, 2, 2, 0, 0, 1, 1, 0, 0, 0), 1'b1);
    push(mk(im, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0), 1'($urandom_range(0, 1)));
    case (o)
      7'h03: begin
        push(mk(im, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0), 1'($urandom_range(0, 1)));
        for (int i = 0; i < mwait; i++) push(mk(im, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0), 1'b0);
        push(mk(im, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0), 1'b1);
        push(mk(im, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0), 1'($urandom_range(0, 1)));
      end
      7'h23: begin
        push(mk(im, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0), 1'($urandom_range(0, 1)));
        for (int i = 0; i < mwait; i++) push(mk(im, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0), 1'b0);
        push(mk(im, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0), 1'b1);
      end
      7'h33, 7'h13: begin
        push(mk(im, 2, (o == 7'h13) ? 2'd1 : 2'd0, 0, exp_alu(o, f3, f7), 0, 0, 0, 0, 0, 0),
             1'($urandom_range(0, 1)));
        push(mk(im, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0), 1'($urandom_range(0, 1)));
      end
      7'h6F: begin
        push(mk(im, 1, 2, 0, 0, 0, 0, 1, 0, 0, 0), 1'($urandom_range(0, 1)));
        push(mk(im, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0), 1'($urandom_range(0, 1)));
      end
      7'h63: begin
        s = '{mk(im, 2, 0, 0, 3'b001, 0, 0, z, 0, 0, 0), 1'($urandom_range(0, 1)), z};
        plan.push_back(s);
      end
      default: ;
    endcase
  endtask

  // Entered at posedge+1 with both DUTs in FETCH; leaves at posedge+1.
  task automatic run_plan(input string name);
    int n;
    step_t s;
    n = 0;
    while (plan.size() > 0) begin
      s = plan.pop_front();
      mem_ready = s.mr;
      zero      = s.z;
      @(negedge clk);
      chk($sformatf("%s_c%0d_trap", name, n), obs_t, s.e);
      chk($sformatf("%s_c%0d_notrap", name, n), obs_n, s.e);
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic do_reset(input string name);
    outv_t f;
    f = mk(exp_imm(op), 0, 2, 2, 0, 0, 0, 0, 0, 0, 0);
    reset_n   = 1'b0;
    mem_ready = 1'b1;
    #1;
    chk({name, "_in_reset"}, obs_t, f);
    @(posedge clk); #1;
    chk({name, "_hold_reset"}, obs_n, f);
    mem_ready = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk({name, "_released_t"}, obs_t, f);
    chk({name, "_released_n"}, obs_n, f);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [6:0] ops [6];
    outv_t      tv, fv;
    int         k;
    ops = '{7'h03, 7'h23, 7'h33, 7'h13, 7'h63, 7'h6F};
    op = 7'h33; funct3 = 3'd0; funct7b5 = 1'b0; zero = 1'b0; mem_ready = 1'b0; reset_n = 1'b0;
    #1;
    do_reset("por");

    // Reset arriving while a store is being held in MEMWRITE.
    op = 7'h23; funct3 = 3'd2; mem_ready = 1'b1;
    @(posedge clk); #1;
    mem_ready = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("memwrite_held", obs_t, mk(2'b01, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0));
    #2;
    mem_ready = 1'b1;
    reset_n   = 1'b0;
    #1;
    chk("reset_mid_memwrite", obs_t, mk(2'b01, 0, 2, 2, 0, 0, 0, 0, 0, 0, 0));
    @(posedge clk); #1;
    chk("reset_mid_hold", obs_n, mk(2'b01, 0, 2, 2, 0, 0, 0, 0, 0, 0, 0));
    mem_ready = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("reset_mid_release", obs_t, mk(2'b01, 0, 2, 2, 0, 0, 0, 0, 0, 0, 0));
    @(posedge clk); #1;

    // Directed: add, sub, lw with two waits, beq taken/not taken, jal, sw with one wait.
    op = 7'h33; funct3 = 3'd0; funct7b5 = 1'b0; plan_instr(op, funct3, funct7b5, 1'b0, 0, 0); run_plan("add");
    funct7b5 = 1'b1; plan_instr(op, funct3, funct7b5, 1'b0, 0, 0); run_plan("sub");
    op = 7'h03; funct3 = 3'd2; funct7b5 = 1'b0; plan_instr(op, funct3, funct7b5, 1'b0, 0, 2); run_plan("lw_wait2");
    op = 7'h63; funct3 = 3'd0; plan_instr(op, funct3, funct7b5, 1'b1, 0, 0); run_plan("beq_taken");
    plan_instr(op, funct3, funct7b5, 1'b0, 1, 0); run_plan("beq_not_taken");
    op = 7'h6F; plan_instr(op, funct3, funct7b5, 1'b0, 0, 0); run_plan("jal");
    op = 7'h23; funct3 = 3'd2; plan_instr(op, funct3, funct7b5, 1'b0, 0, 1); run_plan("sw_wait1");

    // Randomized instruction stream.
    for (int i = 0; i < 60; i++) begin
      op       = ops[$urandom_range(0, 5)];
      funct3   = 3'($urandom_range(0, 7));
      funct7b5 = 1'($urandom_range(0, 1));
      plan_instr(op, funct3, funct7b5, 1'($urandom_range(0, 1)),
                 $urandom_range(0, 2), $urandom_range(0, 3));
      run_plan($sformatf("rnd%0d", i));
    end

    // Unsupported opcode: trapping instance stays in TRAP, the other returns to FETCH.
    op = 7'h7F; funct3 = 3'($urandom_range(0, 7));
    plan_instr(op, funct3, 1'b0, 1'b0, 0, 0);
    run_plan("ill_front");
    tv = mk(2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    fv = mk(2'b00, 0, 2, 2, 0, 0, 0, 0, 0, 0, 0);
    mem_ready = 1'b0;
    @(negedge clk);
    chk("ill_trap_entered", obs_t, tv);
    chk("ill_notrap_fetch", obs_n, fv);
    @(posedge clk); #1;
    k = 0;
    repeat (20) begin
      mem_ready = 1'($urandom_range(0, 1));
      zero      = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk($sformatf("trap_stay%0d", k), obs_t, tv);
      @(posedge clk); #1;
      k++;
    end
    do_reset("trap_exit");
    op = 7'h13; funct3 = 3'd7; funct7b5 = 1'b1;
    plan_instr(op, funct3, funct7b5, 1'b0, 0, 0);
    run_plan("after_trap");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
